// File: rtl/iir_1_inv.sv
// ============================================================================
// Module   : iir_1_inv
// Purpose  : Inverse of the first-order IIR y(n) = x(n) + A*y(n-1); recovers
//            x(n) = y(n) - A*y(n-1) through a 3-stage pipeline.
// Options  : define IIR_1_INV_SAT_EN to clip x_out to [-128,127] and flag sat;
//            otherwise x_out wraps and sat is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_1_inv #(
  parameter logic signed [15:0] A = 16'sd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [16:0]  y_in,
  output logic                out_valid,
  output logic signed [7:0]   x_out,
  output logic                sat
);

  logic signed [16:0] r_yh;
  logic signed [32:0] r_p1;
  logic signed [32:0] r_p2;
  logic signed [16:0] r_s1;
  logic signed [16:0] r_s2;
  logic               r_v1;
  logic               r_v2;

  logic signed [32:0] w_prod;
  logic signed [33:0] w_diff;
  logic signed [7:0]  w_x;
  logic               w_sat;

  // Both operands sign-extended to the full product width before multiplying.
  assign w_prod = $signed({{17{A[15]}}, A}) * $signed({{16{r_yh[16]}}, r_yh});
  assign w_diff = $signed({{17{r_s2[16]}}, r_s2}) - $signed({r_p2[32], r_p2});

`ifdef IIR_1_INV_SAT_EN
  always_comb begin
    w_x   = w_diff[7:0];
    w_sat = 1'b0;
    if (w_diff > 34'sd127) begin
      w_x   = 8'sd127;
      w_sat = 1'b1;
    end else if (w_diff < -34'sd128) begin
      w_x   = -8'sd128;
      w_sat = 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, w_diff[33:8]};
  always_comb begin
    w_x   = w_diff[7:0];
    w_sat = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_yh      <= '0;
      r_p1      <= '0;
      r_s1      <= '0;
      r_p2      <= '0;
      r_s2      <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
      sat       <= 1'b0;
    end else begin
      // Valid bits always advance; data registers move only with their valid.
      r_v1      <= in_valid;
      r_v2      <= r_v1;
      out_valid <= r_v2;
      if (in_valid) begin
        r_p1 <= w_prod;
        r_s1 <= y_in;
        r_yh <= y_in;
      end
      if (r_v1) begin
        r_p2 <= r_p1;
        r_s2 <= r_s1;
      end
      if (r_v2) begin
        x_out <= w_x;
        sat   <= w_sat;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iir_1_inv.sv
// ============================================================================
// Module   : tb_iir_1_inv
// Purpose  : Scoreboard bench for iir_1_inv with A=1 and A=-1 instances fed
//            the same stream. Honours IIR_1_INV_SAT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iir_1_inv;

  typedef struct {
    int x;
    int s;
    int e;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [16:0] y_in = '0;

  logic               ov_p, sat_p, ov_n, sat_n;
  logic signed [7:0]  x_p, x_n;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   yprev = 0;
  exp_t q_p[$];
  exp_t q_n[$];

  iir_1_inv #(.A(16'sd1)) u_dut_p (
    .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in),
    .out_valid(ov_p), .x_out(x_p), .sat(sat_p)
  );

  iir_1_inv #(.A(-16'sd1)) u_dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in),
    .out_valid(ov_n), .x_out(x_n), .sat(sat_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int y, input int yp, input int edge_n);
    exp_t   r;
    longint d;
    logic [7:0] w;
    d = longint'(y) - longint'(a) * longint'(yp);
`ifdef IIR_1_INV_SAT_EN
    if (d > 127) begin
      r.x = 127; r.s = 1;
    end else if (d < -128) begin
      r.x = -128; r.s = 1;
    end else begin
      r.x = int'(d); r.s = 0;
    end
`else
    w   = d[7:0];
    r.x = int'($signed(w));
    r.s = 0;
`endif
    r.e = edge_n + 2;
    return r;
  endfunction

  // Reference model: runs on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q_p.delete();
      q_n.delete();
      yprev = 0;
    end else if (in_valid) begin
      q_p.push_back(model(1, int'(y_in), yprev, cyc));
      q_n.push_back(model(-1, int'(y_in), yprev, cyc));
      yprev = int'(y_in);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov_p) begin
      if (q_p.size() == 0) check("p_unexpected_valid", 1, 0);
      else begin
        e = q_p.pop_front();
        check("p_x_out", longint'(x_p), e.x);
        check("p_sat", sat_p, e.s);
        check("p_latency_edge", cyc, e.e);
      end
    end
    if (!rst && ov_n) begin
      if (q_n.size() == 0) check("n_unexpected_valid", 1, 0);
      else begin
        e = q_n.pop_front();
        check("n_x_out", longint'(x_n), e.x);
        check("n_sat", sat_n, e.s);
        check("n_latency_edge", cyc, e.e);
      end
    end
  end

  task automatic send(input int y);
    in_valid = 1'b1;
    y_in     = 17'(y);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // in_valid held high during reset must be ignored.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    y_in     = 17'sd777;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_out_valid", ov_p, 0);
    check("reset_x_out", longint'(x_p), 0);
    check("reset_sat", sat_p, 0);
    @(posedge clk); #1;

    send(1); send(2); send(3); send(5);
    idle(5);

    do_reset();
    send(0); send(200);
    idle(5);

    do_reset();
    send(-300);
    idle(5);

    do_reset();
    send(4); idle(3); send(6);
    idle(5);

    do_reset();
    send(3); send(4);
    idle(5);

    // 10's output lands before the reset edge; 20 is still in flight and lost.
    do_reset();
    send(10); idle(1); send(20);
    do_reset();
    send(5);
    idle(5);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      send(int'($urandom_range(0, 131071)) - 65536);
    end
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 400)) - 200);
    end
    idle(6);

    check("p_drain", q_p.size(), 0);
    check("n_drain", q_n.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
